// File: rtl/ppg_led_calibrator.sv
// ppg_led_calibrator: per-channel DC-compensation / PGA gain search for the
// pulse-oximeter front end, followed by time-multiplexed LED acquisition.
module ppg_led_calibrator #(
  parameter int N_CH       = 2,
  parameter int ADC_W      = 8,
  parameter int DC_W       = 7,
  parameter int PGA_W      = 4,
  parameter int DRIVE      = 10,
  parameter int DC_LO      = 110,
  parameter int DC_HI      = 140,
  parameter int CLIP_LO    = 5,
  parameter int CLIP_HI    = 250,
  parameter int SETTLE_CYC = 4,
  parameter int SLOT_CYC   = 16,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic [ADC_W-1:0]        ADC,
  input  logic                    Find_setting,
  output logic [N_CH-1:0]         LED_EN,
  output logic [3:0]              LED_DRIVE,
  output logic [DC_W-1:0]         DC_Comp,
  output logic [PGA_W-1:0]        PGA_Gain,
  output logic                    CLK_Filter,
  output logic [N_CH*ADC_W-1:0]   ADC_Value,
  output logic                    sample_valid,
  output logic [CH_W-1:0]         sample_ch,
  output logic                    calib_done,
  output logic [N_CH-1:0]         calib_err
);

  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int SLOT_W = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;

  localparam logic [ADC_W-1:0] DC_LO_V   = ADC_W'(DC_LO);
  localparam logic [ADC_W-1:0] DC_HI_V   = ADC_W'(DC_HI);
  localparam logic [ADC_W-1:0] CLIP_LO_V = ADC_W'(CLIP_LO);
  localparam logic [ADC_W-1:0] CLIP_HI_V = ADC_W'(CLIP_HI);
  localparam logic [DC_W-1:0]  DC_MID    = DC_W'(1) << (DC_W - 1);
  localparam logic [SET_W-1:0] SETTLE_V  = SET_W'(SETTLE_CYC);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    IDLE,
    DC_SRCH,
    PGA_SRCH,
    NEXT_CH,
    OPERATE
  } state_t;

  state_t               state, state_nxt;
  logic [CH_W-1:0]      ch, ch_nxt;
  logic [SET_W-1:0]     settle, settle_nxt;
  logic [SLOT_W-1:0]    slot, slot_nxt;
  logic [N_CH-1:0]      led, led_nxt;
  logic [DC_W-1:0]      dc, dc_nxt;
  logic [PGA_W-1:0]     pga, pga_nxt;
  logic [DC_W-1:0]      dc_tab [N_CH];
  logic [DC_W-1:0]      dc_tab_nxt [N_CH];
  logic [PGA_W-1:0]     pga_tab [N_CH];
  logic [PGA_W-1:0]     pga_tab_nxt [N_CH];
  logic [N_CH*ADC_W-1:0] adcv, adcv_nxt;
  logic                 valid_nxt;
  logic [CH_W-1:0]      sch, sch_nxt;
  logic [N_CH-1:0]      err, err_nxt;
  logic                 clipped;

  assign clipped = (ADC <= CLIP_LO_V) || (ADC >= CLIP_HI_V);

  // Next-state and next-setting logic; Find_setting low overrides every transition.
  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch;
    settle_nxt  = settle;
    slot_nxt    = slot;
    led_nxt     = led;
    dc_nxt      = dc;
    pga_nxt     = pga;
    dc_tab_nxt  = dc_tab;
    pga_tab_nxt = pga_tab;
    adcv_nxt    = adcv;
    valid_nxt   = 1'b0;
    sch_nxt     = sch;
    err_nxt     = err;

    if (!Find_setting && state != IDLE) begin
      state_nxt   = IDLE;
      ch_nxt      = '0;
      settle_nxt  = '0;
      slot_nxt    = '0;
      led_nxt     = '0;
      dc_nxt      = '0;
      pga_nxt     = '0;
      sch_nxt     = '0;
      dc_tab_nxt  = '{default: '0};
      pga_tab_nxt = '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (Find_setting) begin
            state_nxt  = DC_SRCH;
            ch_nxt     = '0;
            led_nxt    = N_CH'(1);
            dc_nxt     = DC_MID;
            pga_nxt    = '0;
            settle_nxt = SETTLE_V;
            err_nxt    = '0;
          end
        end
        DC_SRCH: begin
          if (settle != '0) begin
            settle_nxt = settle - 1'b1;
          end else begin
            // Every decision restarts the settle window, even one that leaves the code unchanged.
            settle_nxt = SETTLE_V;
            if (ADC < DC_LO_V) begin
              if (dc == '0) begin
                err_nxt[ch]    = 1'b1;
                dc_tab_nxt[ch] = dc;
                state_nxt      = PGA_SRCH;
              end else begin
                dc_nxt = dc - 1'b1;
              end
            end else if (ADC > DC_HI_V) begin
              if (dc == '1) begin
                err_nxt[ch]    = 1'b1;
                dc_tab_nxt[ch] = dc;
                state_nxt      = PGA_SRCH;
              end else begin
                dc_nxt = dc + 1'b1;
              end
            end else begin
              dc_tab_nxt[ch] = dc;
              state_nxt      = PGA_SRCH;
            end
          end
        end
        PGA_SRCH: begin
          if (settle != '0) begin
            settle_nxt = settle - 1'b1;
          end else begin
            settle_nxt = SETTLE_V;
            if (clipped) begin
              if (pga != '0) begin
                pga_tab_nxt[ch] = pga - 1'b1;
                pga_nxt         = pga - 1'b1;
              end else begin
                pga_tab_nxt[ch] = '0;
              end
              led_nxt   = '0;
              state_nxt = NEXT_CH;
            end else if (pga == '1) begin
              pga_tab_nxt[ch] = pga;
              led_nxt         = '0;
              state_nxt       = NEXT_CH;
            end else begin
              pga_nxt = pga + 1'b1;
            end
          end
        end
        NEXT_CH: begin
          if (ch == CH_LAST) begin
            state_nxt = OPERATE;
            ch_nxt    = '0;
            slot_nxt  = '0;
            led_nxt   = N_CH'(1);
            dc_nxt    = dc_tab[0];
            pga_nxt   = pga_tab[0];
          end else begin
            state_nxt  = DC_SRCH;
            ch_nxt     = ch + 1'b1;
            led_nxt    = N_CH'(1) << ch_nxt;
            dc_nxt     = DC_MID;
            pga_nxt    = '0;
            settle_nxt = SETTLE_V;
          end
        end
        OPERATE: begin
          // Settings for a slot are applied on the edge that opens it, so the LED is lit for the whole slot.
          if (slot == SLOT_LAST) begin
            adcv_nxt[ch*ADC_W +: ADC_W] = ADC;
            valid_nxt = 1'b1;
            sch_nxt   = ch;
            ch_nxt    = (ch == CH_LAST) ? '0 : ch + 1'b1;
            slot_nxt  = '0;
            led_nxt   = N_CH'(1) << ch_nxt;
            dc_nxt    = dc_tab[ch_nxt];
            pga_nxt   = pga_tab[ch_nxt];
          end else begin
            slot_nxt = slot + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, settings table and output registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= IDLE;
      ch           <= '0;
      settle       <= '0;
      slot         <= '0;
      led          <= '0;
      dc           <= '0;
      pga          <= '0;
      dc_tab       <= '{default: '0};
      pga_tab      <= '{default: '0};
      adcv         <= '0;
      sample_valid <= 1'b0;
      sch          <= '0;
      err          <= '0;
    end else begin
      state        <= state_nxt;
      ch           <= ch_nxt;
      settle       <= settle_nxt;
      slot         <= slot_nxt;
      led          <= led_nxt;
      dc           <= dc_nxt;
      pga          <= pga_nxt;
      dc_tab       <= dc_tab_nxt;
      pga_tab      <= pga_tab_nxt;
      adcv         <= adcv_nxt;
      sample_valid <= valid_nxt;
      sch          <= sch_nxt;
      err          <= err_nxt;
    end
  end

  // Free-running divide-by-two clock for the analog filter.
  always_ff @(posedge CLK) begin
    if (rst) CLK_Filter <= 1'b0;
    else     CLK_Filter <= ~CLK_Filter;
  end

  assign LED_EN     = led;
  assign DC_Comp    = dc;
  assign PGA_Gain   = pga;
  assign ADC_Value  = adcv;
  assign sample_ch  = sch;
  assign calib_err  = err;
  assign calib_done = (state == OPERATE);
  assign LED_DRIVE  = (state == IDLE) ? 4'd0 : 4'(DRIVE);

endmodule

// File: tb/tb_ppg_led_calibrator.sv
// Self-checking bench for ppg_led_calibrator: a linear front-end model drives
// ADC from the applied settings, and a search model predicts the outcome.
module tb_ppg_led_calibrator;
  localparam int N_CH = 2;
  localparam int ADC_W = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  find;
  logic [ADC_W-1:0]      adc;
  logic [N_CH-1:0]       led_en;
  logic [3:0]            led_drive;
  logic [6:0]            dc_comp;
  logic [3:0]            pga_gain;
  logic                  clk_filter;
  logic [N_CH*ADC_W-1:0] adc_value;
  logic                  sample_valid;
  logic [0:0]            sample_ch;
  logic                  calib_done;
  logic [N_CH-1:0]       calib_err;

  int n_tests = 0;
  int n_fail  = 0;
  int b [2];
  int s [2];

  always #5 clk = ~clk;

  ppg_led_calibrator #(
    .N_CH(2), .ADC_W(8), .DC_W(7), .PGA_W(4), .DRIVE(10),
    .DC_LO(110), .DC_HI(140), .CLIP_LO(5), .CLIP_HI(250),
    .SETTLE_CYC(4), .SLOT_CYC(16)
  ) dut (
    .CLK(clk), .rst(rst), .ADC(adc), .Find_setting(find),
    .LED_EN(led_en), .LED_DRIVE(led_drive), .DC_Comp(dc_comp),
    .PGA_Gain(pga_gain), .CLK_Filter(clk_filter), .ADC_Value(adc_value),
    .sample_valid(sample_valid), .sample_ch(sample_ch),
    .calib_done(calib_done), .calib_err(calib_err)
  );

  // Front end: offset falls one LSB per DC code above mid-scale, gain adds a fixed step.
  function automatic int fe(int bb, int ss, int dcc, int g);
    int v;
    v = bb + 64 - dcc + g * ss;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  always_comb begin
    adc = '0;
    if (led_en == 2'b01)      adc = 8'(fe(b[0], s[0], int'(dc_comp), int'(pga_gain)));
    else if (led_en == 2'b10) adc = 8'(fe(b[1], s[1], int'(dc_comp), int'(pga_gain)));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Search outcome for one channel: final codes, decision counts, error flag.
  task automatic model_ch(input int bb, input int ss, output int dcr, output int pgr,
                          output int nd, output int np, output int er);
    int d;
    int g;
    int v;
    bit done;
    d = 64; g = 0; er = 0; nd = 0; np = 0; done = 0; pgr = 0;
    while (!done) begin
      v = fe(bb, ss, d, 0);
      nd++;
      if (v < 110) begin
        if (d == 0) begin er = 1; done = 1; end
        else d--;
      end else if (v > 140) begin
        if (d == 127) begin er = 1; done = 1; end
        else d++;
      end else done = 1;
    end
    dcr = d;
    done = 0;
    while (!done) begin
      v = fe(bb, ss, d, g);
      np++;
      if (v <= 5 || v >= 250) begin pgr = (g > 0) ? g - 1 : 0; done = 1; end
      else if (g == 15) begin pgr = 15; done = 1; end
      else g++;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_led_en"}, 32'(led_en), 0);
    check({tag, "_led_drive"}, 32'(led_drive), 0);
    check({tag, "_dc"}, 32'(dc_comp), 0);
    check({tag, "_pga"}, 32'(pga_gain), 0);
    check({tag, "_valid"}, 32'(sample_valid), 0);
    check({tag, "_sample_ch"}, 32'(sample_ch), 0);
    check({tag, "_done"}, 32'(calib_done), 0);
  endtask

  initial begin
    int dcr [2];
    int pgr [2];
    int nd [2];
    int np [2];
    int er [2];
    int total;
    int cnt;
    int r;
    int c;
    int exp_val;

    b[0] = 0; b[1] = 0; s[0] = 0; s[1] = 0;
    rst = 1'b1;
    find = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("rst");
      check("rst_clk_filter", 32'(clk_filter), 0);
      check("rst_adc_value", 32'(adc_value), 0);
      check("rst_err", 32'(calib_err), 0);
    end
    find = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("clk_filter_toggle", 32'(clk_filter), (i % 2 == 0) ? 1 : 0);
    end
    check_idle("idle");

    for (int run = 0; run < 8; run++) begin
      if (run == 0) begin
        b[0] = 105; s[0] = 10; b[1] = 250; s[1] = 10;
      end else if (run == 1) begin
        b[0] = 10;  s[0] = 0;  b[1] = 125; s[1] = 30;
      end else begin
        for (int k = 0; k < 2; k++) begin
          b[k] = int'($urandom_range(0, 255));
          s[k] = int'($urandom_range(0, 30));
        end
      end
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int k = 0; k < 2; k++) model_ch(b[k], s[k], dcr[k], pgr[k], nd[k], np[k], er[k]);
      total = 1;
      for (int k = 0; k < 2; k++) total += 5 * (nd[k] + np[k]) + 1;

      find = 1'b1;
      cnt = 0;
      if (run % 2 == 1) begin
        r = int'($urandom_range(2, total - 2));
        repeat (r) step();
        find = 1'b0;
        step();
        check_idle("abort");
        check("abort_adc_value", 32'(adc_value), 0);
        find = 1'b1;
        step();
        check("restart_led_en", 32'(led_en), 1);
        check("restart_dc", 32'(dc_comp), 64);
        check("restart_pga", 32'(pga_gain), 0);
        check("restart_drive", 32'(led_drive), 10);
        cnt = 1;
      end
      while (!calib_done && cnt < total + 50) begin
        step();
        cnt++;
      end
      check("calib_time", 32'(cnt), 32'(total));
      check("calib_err", 32'(calib_err), 32'(er[0] + 2 * er[1]));

      for (int t = 0; t <= 64; t++) begin
        if (t > 0) step();
        check("op_done", 32'(calib_done), 1);
        if (t > 0 && t % 16 == 0) begin
          c = (t / 16 - 1) % 2;
          exp_val = fe(b[c], s[c], dcr[c], pgr[c]);
          check("op_valid", 32'(sample_valid), 1);
          check("op_sample_ch", 32'(sample_ch), 32'(c));
          check("op_lane", 32'(adc_value[c*ADC_W +: ADC_W]), 32'(exp_val));
        end else begin
          check("op_valid_idle", 32'(sample_valid), 0);
        end
        if (t % 16 == 8) begin
          c = (t / 16) % 2;
          check("op_led_en", 32'(led_en), 32'(1 << c));
          check("op_dc", 32'(dc_comp), 32'(dcr[c]));
          check("op_pga", 32'(pga_gain), 32'(pgr[c]));
          check("op_drive", 32'(led_drive), 10);
        end
      end
      exp_val = fe(b[1], s[1], dcr[1], pgr[1]) * 256 + fe(b[0], s[0], dcr[0], pgr[0]);
      check("op_adc_value", 32'(adc_value), 32'(exp_val));
      find = 1'b0;
      step();
      check_idle("stop");
      check("stop_adc_value", 32'(adc_value), 32'(exp_val));
      check("stop_err", 32'(calib_err), 32'(er[0] + 2 * er[1]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
